rom_arbiter: RTL

Shares the single-port synchronous instruction ROM between the fetch unit's instruction bus and the load path's data bus. Grants one requester per cycle, drives the ROM port and steers the one-cycle-late read data back to the winner. Holds each port's last returned word. With the fairness option compiled in, it guarantees fetch forward progress under sustained loads. Sits between `fetch`/load-store and the ROM macro in the core.

---
 rtl/core_pkg.sv | 14 +
 rtl/rom_starve_counter.sv | 39 +++
 rtl/rom_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the ROM arbiter slice.
package core_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } rom_owner_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/rom_starve_counter.sv
// Saturating count of consecutive cycles the fetch port was denied the ROM.
// limit_hit gives fetch priority for the current cycle.
module rom_starve_counter
    import core_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic starved,
    output logic limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] count_reg;
    logic [STARVE_CNT_W-1:0] count_next;

    assign limit_hit = (count_reg == LIMIT_C);

    // A granted or idle fetch port restarts the count.
    always_comb begin
        count_next = count_reg;
        if (!starved) begin
            count_next = '0;
        end else if (!limit_hit) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for the single-port instruction ROM (fetch and load buses).
// Define ROM_ARB_FAIRNESS_EN to add fetch starvation protection.
module rom_arbiter
    import core_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int ROM_ADDR_WIDTH = 10,
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ibus_req,
    input  logic [ROM_ADDR_WIDTH-1:0] ibus_addr,
    output logic                      ibus_gnt,
    output logic                      ibus_rvalid,
    output logic [WIDTH-1:0]          ibus_rd_data,
    input  logic                      dbus_req,
    input  logic [ROM_ADDR_WIDTH-1:0] dbus_addr,
    output logic                      dbus_gnt,
    output logic                      dbus_rvalid,
    output logic [WIDTH-1:0]          dbus_rd_data,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]          rom_rd_data
);

    localparam int NUM_PORTS = 2;

    rom_owner_t owner_reg;
    rom_owner_t owner_next;
    logic       limit_hit;

`ifdef ROM_ARB_FAIRNESS_EN
    rom_starve_counter #(
        .LIMIT     (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .starved   (ibus_req & ~ibus_gnt),
        .limit_hit (limit_hit)
    );
`else
    // Limits below 1 are illegal, so this is constant 0: strict load priority.
    assign limit_hit = (STARVE_LIMIT < 1);
`endif

    // Load wins ties unless fetch has been starved up to the limit.
    always_comb begin
        ibus_gnt = rst_n & ibus_req & (~dbus_req | limit_hit);
        dbus_gnt = rst_n & dbus_req & ~(ibus_req & limit_hit);
        rom_en   = ibus_gnt | dbus_gnt;
        rom_addr = '0;
        if (dbus_gnt) begin
            rom_addr = dbus_addr;
        end else if (ibus_gnt) begin
            rom_addr = ibus_addr;
        end
    end

    always_comb begin
        owner_next = NONE;
        if (dbus_gnt) begin
            owner_next = DBUS;
        end else if (ibus_gnt) begin
            owner_next = IBUS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // Index 0 is fetch, index 1 is load.
    logic [NUM_PORTS-1:0] ret_sel;
    logic [WIDTH-1:0]     rd_data_reg [NUM_PORTS];
    logic [WIDTH-1:0]     rd_data_out [NUM_PORTS];

    assign ret_sel = {owner_reg == DBUS, owner_reg == IBUS};

    // The returning word is forwarded in its rvalid cycle and held afterwards.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_reg[gi] <= '0;
                end else if (ret_sel[gi]) begin
                    rd_data_reg[gi] <= rom_rd_data;
                end
            end
            assign rd_data_out[gi] = ret_sel[gi] ? rom_rd_data : rd_data_reg[gi];
        end
    endgenerate

    assign ibus_rvalid  = ret_sel[0];
    assign dbus_rvalid  = ret_sel[1];
    assign ibus_rd_data = rd_data_out[0];
    assign dbus_rd_data = rd_data_out[1];

endmodule
